i2c_txn_sequencer: RTL and testbench
====================================

// Module: i2c_txn_sequencer
// PURPOSE
// - Command-queue front end for the I2C master. Buffers write/read requests in a FIFO and
//   issues them one at a time on the master's start/addr/rw/data_in pins.
// - Detects completion from the master state bus and returns one response per command
//   (read data, NACK, timeout).
// - Sits directly upstream of top_i2c; cmd_* comes from the system, rsp_* goes back to it.
// PARAMETERS
// - CMD_DEPTH    4      command FIFO entries; power of 2, >=2
// - IDLE_ST      3'd0   master state encoding meaning idle
// - TIMEOUT_CYC  4096   max clk cycles per phase (WAIT_BUSY or WAIT_DONE) before abort; <2^16
// - MAX_RETRY    2      NACK retries; used only with I2C_RETRY_EN
// PORTS
// - clk          in   1   system clock; all logic on rising edge
// - reset        in   1   synchronous, active-high reset
// - cmd_valid    in   1   command offered
// - cmd_ready    out  1   FIFO not full; push when cmd_valid & cmd_ready
// - cmd_addr     in   7   7-bit slave address
// - cmd_rw       in   1   1 = read, 0 = write
// - cmd_wdata    in   8   write byte (ignored for reads)
// - rsp_valid    out  1   response held until accepted
// - rsp_ready    in   1   response consumed when rsp_valid & rsp_ready
// - rsp_rdata    out  8   read byte; 8'h00 for writes and for errors
// - rsp_nack     out  1   master reported ack_error
// - rsp_timeout  out  1   phase exceeded TIMEOUT_CYC
// - mst_start    out  1   one-cycle start pulse to master
// - mst_addr     out  7   registered address, stable from pulse until response
// - mst_rw       out  1   registered rw, same stability rule
// - mst_wdata    out  8   registered write byte, same stability rule
// - mst_rdata    in   8   master data_out
// - mst_ack_err  in   1   master ack_error
// - mst_state    in   3   master state bus
// - busy         out  1   FSM not in IDLE
// - cmd_count    out  $clog2(CMD_DEPTH)+1   FIFO occupancy
// BEHAVIOUR
// - Reset: FIFO empty, FSM=IDLE. cmd_ready=1; cmd_count=0. rsp_valid=0; rsp_rdata=0;
//   rsp_nack=0; rsp_timeout=0. mst_start=0; mst_addr=0; mst_rw=0; mst_wdata=0; busy=0.
// - Reset mid-transaction drops all queued commands and any pending response; no response is emitted.
// - FIFO
//   - Push on cmd_valid & cmd_ready; pop on the IDLE->ISSUE transition.
//   - Simultaneous push and pop keeps the count unchanged and is legal when full.
//   - cmd_ready = (count < CMD_DEPTH) | pop_this_cycle.
//   - Pointers wrap modulo CMD_DEPTH.
// - FSM
//   - IDLE: if count > 0, pop head into mst_* regs; go ISSUE.
//   - ISSUE: mst_start=1 for exactly this cycle; clear timer; go WAIT_BUSY.
//   - WAIT_BUSY: if mst_state != IDLE_ST, clear timer and go WAIT_DONE.
//     Else if timer == TIMEOUT_CYC-1, timeout.
//   - WAIT_DONE: if mst_state == IDLE_ST, capture and go RESP.
//     Else if timer == TIMEOUT_CYC-1, timeout.
//   - Capture: rsp_rdata = (mst_rw & ~mst_ack_err) ? mst_rdata : 0; rsp_nack = mst_ack_err.
//   - Timeout: rsp_timeout=1, rsp_nack=0, rsp_rdata=0; go RESP.
//   - RESP: rsp_valid=1; on rsp_ready, drop rsp_valid the next cycle and go IDLE.
//   - Minimum latency from pop to rsp_valid: 4 cycles (master done instantly).
//   - Back-to-back: the next pop can occur in the cycle after the handshake.
// - Timer: 16-bit, saturating; compare is exact equality.
// CONFIGURATION
// - I2C_RETRY_EN defined:
//   - On NACK with retry_cnt < MAX_RETRY: increment retry_cnt and go ISSUE with the same
//     mst_* values.
//   - Otherwise respond with rsp_nack=1.
//   - retry_cnt clears on pop.
//   - Timeouts are never retried.
// - I2C_RETRY_EN undefined: NACK responds immediately; no retry counter is synthesised.
// TESTING
// - Write: push addr=7'h50 rw=0 wdata=8'hA5; master busy 20 cycles, ack ok
//   -> one mst_start pulse, mst_addr=7'h50, response rdata=8'h00, nack=0, timeout=0.
// - Read: push addr=7'h3C rw=1; master returns 8'h5A
//   -> rsp_rdata=8'h5A; rsp_valid held 3 cycles with rsp_ready=0, data stable throughout.
// - Full FIFO: push 5 cmds with CMD_DEPTH=4 and master stalled -> cmd_ready=0 after 4th
//   push, cmd_count=4; 5th accepted on pop cycle; responses in push order.
// - NACK: master ack_error=1 -> rsp_nack=1, rsp_rdata=0. With I2C_RETRY_EN and MAX_RETRY=2
//   -> 3 start pulses, then rsp_nack=1. A second-attempt ack -> nack=0.
// - Timeout: mst_state stuck at IDLE_ST, TIMEOUT_CYC=16 -> rsp_timeout=1 exactly 16 cycles
//   after WAIT_BUSY entry.
// - Reset asserted in WAIT_DONE with 2 queued -> all outputs at reset values next cycle,
//   cmd_count=0, no rsp_valid.

Source files
------------

// File: rtl/i2c_txn_sequencer.sv
// Command-queue front end for the I2C master: FIFOs write/read requests, issues them one at a time,
// and returns one response per command. Optional NACK retry is enabled by defining I2C_RETRY_EN.
module i2c_txn_sequencer #(
  parameter int unsigned CMD_DEPTH   = 4,
  parameter logic [2:0]  IDLE_ST     = 3'd0,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [6:0]                     cmd_addr,
  input  logic                           cmd_rw,
  input  logic [7:0]                     cmd_wdata,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [7:0]                     rsp_rdata,
  output logic                           rsp_nack,
  output logic                           rsp_timeout,
  output logic                           mst_start,
  output logic [6:0]                     mst_addr,
  output logic                           mst_rw,
  output logic [7:0]                     mst_wdata,
  input  logic [7:0]                     mst_rdata,
  input  logic                           mst_ack_err,
  input  logic [2:0]                     mst_state,
  output logic                           busy,
  output logic [$clog2(CMD_DEPTH):0]     cmd_count
);

  localparam int unsigned PW       = $clog2(CMD_DEPTH);
  localparam int unsigned CW       = PW + 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t state, state_nx;

  logic [6:0]    fifo_addr  [CMD_DEPTH];
  logic          fifo_rw    [CMD_DEPTH];
  logic [7:0]    fifo_wdata [CMD_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;
  logic [15:0]   timer;
  logic          timer_clr, do_capture, do_timeout;

`ifdef I2C_RETRY_EN
  localparam int unsigned RCW = $clog2(MAX_RETRY + 1) + 1;
  logic [RCW-1:0] retry_cnt;
  logic           do_retry;
`endif

  // Pop is the IDLE->ISSUE transition; it frees a slot in the same cycle so a full FIFO can still accept.
  assign pop       = (state == S_IDLE) && (count != '0);
  assign cmd_ready = (count < CW'(CMD_DEPTH)) || pop;
  assign push      = cmd_valid && cmd_ready;
  assign cmd_count = count;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    timer_clr  = 1'b0;
    do_capture = 1'b0;
    do_timeout = 1'b0;
    mst_start  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = (state != S_IDLE);
`ifdef I2C_RETRY_EN
    do_retry   = 1'b0;
`endif
    case (state)
      S_IDLE:      if (count != '0) state_nx = S_ISSUE;
      S_ISSUE: begin
        mst_start = 1'b1;
        timer_clr = 1'b1;
        state_nx  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (mst_state != IDLE_ST) begin
          timer_clr = 1'b1;
          state_nx  = S_WAIT_DONE;
        end else if (timer == TMO_LAST) begin
          do_timeout = 1'b1;
          state_nx   = S_RESP;
        end
      end
      S_WAIT_DONE: begin
        if (mst_state == IDLE_ST) begin
`ifdef I2C_RETRY_EN
          if (mst_ack_err && (retry_cnt < RCW'(MAX_RETRY))) begin
            do_retry = 1'b1;
            state_nx = S_ISSUE;
          end else begin
            do_capture = 1'b1;
            state_nx   = S_RESP;
          end
`else
          do_capture = 1'b1;
          state_nx   = S_RESP;
`endif
        end else if (timer == TMO_LAST) begin
          do_timeout = 1'b1;
          state_nx   = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = S_IDLE;
      end
      default:     state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= cmd_addr;
      fifo_rw[wr_ptr]    <= cmd_rw;
      fifo_wdata[wr_ptr] <= cmd_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (timer_clr) begin
      timer <= '0;
    end else if (((state == S_WAIT_BUSY) || (state == S_WAIT_DONE)) && (timer != '1)) begin
      timer <= timer + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mst_addr  <= '0;
      mst_rw    <= 1'b0;
      mst_wdata <= '0;
    end else if (pop) begin
      mst_addr  <= fifo_addr[rd_ptr];
      mst_rw    <= fifo_rw[rd_ptr];
      mst_wdata <= fifo_wdata[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata   <= '0;
      rsp_nack    <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (do_capture) begin
      rsp_rdata   <= (mst_rw && !mst_ack_err) ? mst_rdata : 8'h00;
      rsp_nack    <= mst_ack_err;
      rsp_timeout <= 1'b0;
    end else if (do_timeout) begin
      rsp_rdata   <= '0;
      rsp_nack    <= 1'b0;
      rsp_timeout <= 1'b1;
    end
  end

`ifdef I2C_RETRY_EN
  always_ff @(posedge clk) begin
    if (reset)         retry_cnt <= '0;
    else if (pop)      retry_cnt <= '0;
    else if (do_retry) retry_cnt <= retry_cnt + RCW'(1);
  end
`endif

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer with a behavioural I2C master and an expected-response queue.
module tb_i2c_txn_sequencer;

  localparam int unsigned T_CYC = 16;
`ifdef I2C_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = '0;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       rsp_nack, rsp_timeout;
  logic       mst_start;
  logic [6:0] mst_addr;
  logic       mst_rw;
  logic [7:0] mst_wdata;
  logic [7:0] mst_rdata = '0;
  logic       mst_ack_err = 1'b0;
  logic [2:0] mst_state = '0;
  logic       busy;
  logic [2:0] cmd_count;

  always #5 clk = ~clk;

  i2c_txn_sequencer #(
    .CMD_DEPTH  (4),
    .IDLE_ST    (3'd0),
    .TIMEOUT_CYC(T_CYC),
    .MAX_RETRY  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_rw     (cmd_rw),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_nack   (rsp_nack),
    .rsp_timeout(rsp_timeout),
    .mst_start  (mst_start),
    .mst_addr   (mst_addr),
    .mst_rw     (mst_rw),
    .mst_wdata  (mst_wdata),
    .mst_rdata  (mst_rdata),
    .mst_ack_err(mst_ack_err),
    .mst_state  (mst_state),
    .busy       (busy),
    .cmd_count  (cmd_count)
  );

  // Behavioural master: goes busy after a start, stays busy m_busy cycles (or forever while m_hold),
  // then returns idle with data; attempts 1..m_nack_n since m_base report ack_error.
  int         m_busy = 3;
  bit         m_hold = 1'b0;
  bit         m_respond = 1'b1;
  int         m_nack_n = 0;
  int         m_base = 0;
  int         m_attempt = 0;
  int         m_cnt = 0;
  logic [7:0] m_rdata_cfg = '0;
  int         start_cnt = 0;

  always @(posedge clk) begin
    logic s_start, s_rst;
    s_start = mst_start;
    s_rst   = reset;
    if (s_start) start_cnt++;
    #1;
    if (s_rst) begin
      mst_state   = '0;
      mst_ack_err = 1'b0;
      mst_rdata   = '0;
    end else if (s_start && m_respond) begin
      m_attempt++;
      mst_state   = 3'd2;
      m_cnt       = m_busy;
      mst_ack_err = 1'b0;
      mst_rdata   = '0;
    end else if (mst_state != 3'd0 && !m_hold) begin
      if (m_cnt > 1) m_cnt--;
      else begin
        mst_state   = 3'd0;
        mst_ack_err = ((m_attempt - m_base) <= m_nack_n);
        mst_rdata   = m_rdata_cfg;
      end
    end
  end

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       nack;
    logic       timeout;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_add(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                        input logic en, input logic eto);
    exp_t e;
    e.addr = a; e.rw = rw; e.wdata = wd; e.nack = en; e.timeout = eto;
    e.rdata = (rw && !en && !eto) ? m_rdata_cfg : 8'h00;
    sb.push_back(e);
  endtask

  task automatic push_cmd(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                          input logic en, input logic eto);
    int n = 0;
    cmd_valid = 1'b1; cmd_addr = a; cmd_rw = rw; cmd_wdata = wd;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("push_accept", 32'(n < 100), 1);
    sb_add(a, rw, wd, en, eto);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input int hold, input bit ack);
    int   n = 0;
    exp_t e;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    chk("rsp_valid_wait", rsp_valid, 1);
    chk("sb_empty", 32'(sb.size() == 0), 0);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_nack", rsp_nack, e.nack);
    chk("rsp_timeout", rsp_timeout, e.timeout);
    chk("mst_addr", mst_addr, e.addr);
    chk("mst_rw", mst_rw, e.rw);
    chk("mst_wdata", mst_wdata, e.wdata);
    repeat (hold) begin
      @(negedge clk);
      chk("rsp_hold_valid", rsp_valid, 1);
      chk("rsp_hold_rdata", rsp_rdata, e.rdata);
    end
    if (ack) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_drop", rsp_valid, 0);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_cmd_count", cmd_count, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_nack", rsp_nack, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_mst_start", mst_start, 0);
    chk("rst_mst_addr", mst_addr, 0);
    chk("rst_mst_rw", mst_rw, 0);
    chk("rst_mst_wdata", mst_wdata, 0);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, k;
    bit seen;
    repeat (3) @(negedge clk);
    chk_reset_state();
    reset = 1'b0;
    @(negedge clk);

    // Write: response carries no data even though the master drives some.
    m_busy = 10; m_rdata_cfg = 8'h77; m_nack_n = 0; m_base = m_attempt; s0 = start_cnt;
    push_cmd(7'h50, 1'b0, 8'hA5, 1'b0, 1'b0);
    get_rsp(0, 1'b1);
    chk("write_starts", start_cnt - s0, 1);

    // Read held three cycles with rsp_ready low.
    m_busy = 4; m_rdata_cfg = 8'h5A; s0 = start_cnt;
    push_cmd(7'h3C, 1'b1, 8'h00, 1'b0, 1'b0);
    get_rsp(3, 1'b1);
    chk("read_starts", start_cnt - s0, 1);

    // Full FIFO: cmd0 parked in RESP, four more fill the queue, fifth enters on the pop cycle.
    m_busy = 2; m_rdata_cfg = 8'h00;
    push_cmd(7'h10, 1'b0, 8'h01, 1'b0, 1'b0);
    get_rsp(0, 1'b0);
    for (int i = 1; i <= 4; i++) push_cmd(7'(8'h10 + i), 1'b0, 8'(i + 1), 1'b0, 1'b0);
    chk("full_count", cmd_count, 4);
    chk("full_ready", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_addr = 7'h15; cmd_rw = 1'b0; cmd_wdata = 8'h06;
    @(negedge clk);
    chk("full_ready_stall", cmd_ready, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("full_rsp_drop", rsp_valid, 0);
    chk("full_ready_on_pop", cmd_ready, 1);
    chk("full_count_pop", cmd_count, 4);
    sb_add(7'h15, 1'b0, 8'h06, 1'b0, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("full_count_pushpop", cmd_count, 4);
    for (int i = 0; i < 5; i++) get_rsp(0, 1'b1);

    // NACK on every attempt, read data must be suppressed.
    m_busy = 3; m_rdata_cfg = 8'hEE; m_nack_n = 99; m_base = m_attempt; s0 = start_cnt;
    push_cmd(7'h22, 1'b1, 8'h00, 1'b1, 1'b0);
    get_rsp(0, 1'b1);
    chk("nack_starts", start_cnt - s0, RETRY ? 3 : 1);

    // First attempt NACKs, second acks.
    m_nack_n = 1; m_base = m_attempt; s0 = start_cnt;
    push_cmd(7'h23, 1'b0, 8'h42, RETRY ? 1'b0 : 1'b1, 1'b0);
    get_rsp(0, 1'b1);
    chk("nack2_starts", start_cnt - s0, RETRY ? 2 : 1);
    m_nack_n = 0;

    // Timeout: master never leaves idle.
    m_respond = 1'b0; s0 = start_cnt;
    push_cmd(7'h33, 1'b1, 8'h00, 1'b0, 1'b1);
    k = 0;
    while (!mst_start && k < 50) begin @(negedge clk); k++; end
    chk("tmo_start_seen", mst_start, 1);
    k = 0;
    while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
    chk("tmo_latency", k, T_CYC + 1);
    get_rsp(0, 1'b1);
    chk("tmo_starts", start_cnt - s0, 1);
    m_respond = 1'b1;

    // Reset while in WAIT_DONE with two commands queued.
    m_hold = 1'b1; m_busy = 3;
    push_cmd(7'h41, 1'b0, 8'h11, 1'b0, 1'b0);
    push_cmd(7'h42, 1'b0, 8'h12, 1'b0, 1'b0);
    push_cmd(7'h43, 1'b0, 8'h13, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_count", cmd_count, 2);
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state();
    reset = 1'b0; m_hold = 1'b0;
    sb.delete();
    s0 = start_cnt; seen = 1'b0;
    repeat (10) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
    chk("post_rst_no_rsp", seen, 0);
    chk("post_rst_no_start", start_cnt - s0, 0);

    // Recovery after reset.
    m_rdata_cfg = 8'h3C; m_base = m_attempt;
    push_cmd(7'h11, 1'b1, 8'h00, 1'b0, 1'b0);
    get_rsp(1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
